// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/ready bus between fetch and imem.
// Master drives req/addr; slave answers with ready/rdata.
interface if_fetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata
   );
endinterface

// File: rtl/if_fetch_stage.sv
// RISC-V instruction fetch: PC, imem handshake, ID bundle,
// one-entry skid buffer and EX redirect handling.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0200,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall_ID,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   if_fetch_stage_if.master  imem,
   output logic              valid_ID,
   output logic [31:0]       instr_ID,
   output logic [31:0]       PC_ID,
   output logic [31:0]       PCplus4_ID
);

   typedef enum logic [1:0] {
      BOOT,
      REQ,
      DRAIN
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [31:0] fetch_pc_q;
   logic [31:0] fetch_pc_d;
   logic [31:0] target_q;
   logic [31:0] target_d;
   logic [31:0] redir_tgt;
   logic [31:0] pc_inc;
   logic        skid_valid_q;
   logic [31:0] skid_instr_q;
   logic [31:0] skid_pc_q;
   logic [31:0] skid_pc4;
   logic        req;
   logic        accept;
   logic        id_free;

   assign redir_tgt = {redirect_pc[31:2], 2'b00};
   assign pc_inc    = fetch_pc_q + 32'd4;
   assign skid_pc4  = skid_pc_q + 32'd4;
   assign id_free   = !valid_ID || !stall_ID;

   // A killed or redirected cycle never delivers its response.
   assign accept = (state_q == REQ) && req
                && imem.imem_ready && !redirect_valid;

   assign imem.imem_req  = req && !reset;
   assign imem.imem_addr = fetch_pc_q;

   // Next-state, next-PC and request generation.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      target_d   = target_q;
      req        = 1'b0;
      unique case (state_q)
         BOOT: begin
            state_d = REQ;
            if (redirect_valid)
               fetch_pc_d = redir_tgt;
         end
         REQ: begin
            // A full skid blocks new requests.
            req = !skid_valid_q;
            if (redirect_valid) begin
               if (req && !imem.imem_ready) begin
                  target_d = redir_tgt;
                  state_d  = DRAIN;
               end else begin
                  fetch_pc_d = redir_tgt;
               end
            end else if (req && imem.imem_ready) begin
               fetch_pc_d = pc_inc;
            end
         end
         DRAIN: begin
            // Keep the stale request up until memory completes it.
            req = 1'b1;
            if (imem.imem_ready) begin
               state_d    = REQ;
               fetch_pc_d = redirect_valid ? redir_tgt
                                           : target_q;
            end else if (redirect_valid) begin
               target_d = redir_tgt;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   // FSM, fetch PC and saved redirect target registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= BOOT;
         fetch_pc_q <= RESET_PC;
         target_q   <= 32'd0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         target_q   <= target_d;
      end
   end

   // ID bundle and skid buffer; redirect outranks everything.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_ID     <= 1'b0;
         instr_ID     <= NOP_INSTR;
         PC_ID        <= 32'd0;
         PCplus4_ID   <= 32'd0;
         skid_valid_q <= 1'b0;
         skid_instr_q <= 32'd0;
         skid_pc_q    <= 32'd0;
      end else if (redirect_valid) begin
         valid_ID     <= 1'b0;
         instr_ID     <= NOP_INSTR;
         skid_valid_q <= 1'b0;
      end else if (id_free) begin
         if (skid_valid_q) begin
            valid_ID     <= 1'b1;
            instr_ID     <= skid_instr_q;
            PC_ID        <= skid_pc_q;
            PCplus4_ID   <= skid_pc4;
            skid_valid_q <= 1'b0;
         end else if (accept) begin
            valid_ID   <= 1'b1;
            instr_ID   <= imem.imem_rdata;
            PC_ID      <= fetch_pc_q;
            PCplus4_ID <= pc_inc;
         end else begin
            valid_ID <= 1'b0;
            instr_ID <= NOP_INSTR;
         end
      end else if (accept) begin
         skid_valid_q <= 1'b1;
         skid_instr_q <= imem.imem_rdata;
         skid_pc_q    <= fetch_pc_q;
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: memory returns
// rdata == addr; expected values are hand-computed.
module tb_if_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        reset;
   logic        stall_ID;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        ready;
   logic        valid_ID;
   logic [31:0] instr_ID;
   logic [31:0] PC_ID;
   logic [31:0] PCplus4_ID;

   int n_vec  = 0;
   int n_miss = 0;

   if_fetch_stage_if bus ();

   assign bus.imem_ready = ready;
   assign bus.imem_rdata = bus.imem_addr;

   if_fetch_stage dut (
      .clk            (clk),
      .reset          (reset),
      .stall_ID       (stall_ID),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem           (bus),
      .valid_ID       (valid_ID),
      .instr_ID       (instr_ID),
      .PC_ID          (PC_ID),
      .PCplus4_ID     (PCplus4_ID)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset          = 1'b1;
      stall_ID       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      ready          = 1'b1;
      #2;
      chk("rst_req",   32'(bus.imem_req), 32'd0);
      chk("rst_valid", 32'(valid_ID), 32'd0);
      chk("rst_instr", instr_ID, NOP);
      chk("rst_pc",    PC_ID, 32'd0);
      chk("rst_pc4",   PCplus4_ID, 32'd0);

      tick;
      reset = 1'b0;
      #1;
      chk("boot_req", 32'(bus.imem_req), 32'd0);

      tick;
      chk("e1_req",   32'(bus.imem_req), 32'd1);
      chk("e1_addr",  bus.imem_addr, 32'h200);
      chk("e1_valid", 32'(valid_ID), 32'd0);

      tick;
      chk("e2_valid", 32'(valid_ID), 32'd1);
      chk("e2_pc",    PC_ID, 32'h200);
      chk("e2_instr", instr_ID, 32'h200);
      chk("e2_pc4",   PCplus4_ID, 32'h204);
      chk("e2_addr",  bus.imem_addr, 32'h204);

      tick;
      chk("e3_pc",   PC_ID, 32'h204);
      chk("e3_addr", bus.imem_addr, 32'h208);
      stall_ID = 1'b1;

      tick;
      chk("st1_pc",  PC_ID, 32'h204);
      chk("st1_req", 32'(bus.imem_req), 32'd0);

      tick;
      chk("st2_pc",    PC_ID, 32'h204);
      chk("st2_valid", 32'(valid_ID), 32'd1);

      tick;
      chk("st3_instr", instr_ID, 32'h204);
      chk("st3_req",   32'(bus.imem_req), 32'd0);
      stall_ID = 1'b0;

      tick;
      chk("rel_pc",    PC_ID, 32'h208);
      chk("rel_instr", instr_ID, 32'h208);
      chk("rel_req",   32'(bus.imem_req), 32'd1);
      chk("rel_addr",  bus.imem_addr, 32'h20C);

      tick;
      chk("e8_pc",   PC_ID, 32'h20C);
      chk("e8_addr", bus.imem_addr, 32'h210);
      ready          = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h1002;

      tick;
      redirect_valid = 1'b0;
      chk("dr1_valid", 32'(valid_ID), 32'd0);
      chk("dr1_instr", instr_ID, NOP);
      chk("dr1_req",   32'(bus.imem_req), 32'd1);
      chk("dr1_addr",  bus.imem_addr, 32'h210);

      tick;
      chk("dr2_addr",  bus.imem_addr, 32'h210);
      chk("dr2_valid", 32'(valid_ID), 32'd0);
      ready = 1'b1;

      tick;
      chk("dr3_valid", 32'(valid_ID), 32'd0);
      chk("dr3_addr",  bus.imem_addr, 32'h1000);
      chk("dr3_req",   32'(bus.imem_req), 32'd1);

      tick;
      chk("tg_valid", 32'(valid_ID), 32'd1);
      chk("tg_pc",    PC_ID, 32'h1000);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h300;

      tick;
      chk("r300_valid", 32'(valid_ID), 32'd0);
      chk("r300_addr",  bus.imem_addr, 32'h300);
      redirect_pc = 32'hFFFF_FFFC;

      tick;
      redirect_valid = 1'b0;
      chk("same_valid", 32'(valid_ID), 32'd0);
      chk("same_instr", instr_ID, NOP);
      chk("same_addr",  bus.imem_addr, 32'hFFFF_FFFC);

      tick;
      chk("wrap_valid", 32'(valid_ID), 32'd1);
      chk("wrap_pc",    PC_ID, 32'hFFFF_FFFC);
      chk("wrap_pc4",   PCplus4_ID, 32'd0);
      chk("wrap_addr",  bus.imem_addr, 32'd0);

      tick;
      chk("z_pc",  PC_ID, 32'd0);
      chk("z_pc4", PCplus4_ID, 32'd4);
      stall_ID = 1'b1;
      ready    = 1'b0;

      tick;
      chk("pend_valid", 32'(valid_ID), 32'd1);
      chk("pend_pc",    PC_ID, 32'd0);
      chk("pend_req",   32'(bus.imem_req), 32'd1);
      chk("pend_addr",  bus.imem_addr, 32'd4);

      reset = 1'b1;
      #1;
      chk("mrst_req",   32'(bus.imem_req), 32'd0);
      chk("mrst_valid", 32'(valid_ID), 32'd0);
      chk("mrst_instr", instr_ID, NOP);
      ready = 1'b1;

      tick;
      reset    = 1'b0;
      stall_ID = 1'b0;
      #1;
      chk("rb_req",   32'(bus.imem_req), 32'd0);
      chk("rb_valid", 32'(valid_ID), 32'd0);

      tick;
      chk("rb1_addr",  bus.imem_addr, 32'h200);
      chk("rb1_req",   32'(bus.imem_req), 32'd1);
      chk("rb1_valid", 32'(valid_ID), 32'd0);

      tick;
      chk("rb2_valid", 32'(valid_ID), 32'd1);
      chk("rb2_pc",    PC_ID, 32'h200);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_miss);
      $finish;
   end

endmodule
